// File: rtl/johnson_decoder_pkg.sv
// johnson_pkg: shared types and Johnson-code helpers.
//   JC_N      code width; the legal sequence has 2*JC_N states
//   IDXW      width of a decoded state index
//   lock_state_e  lock FSM states
//   jc_index / jc_legal  decode and validate one code word
package johnson_pkg;

    localparam int JC_N      = 4;
    localparam int JC_STATES = 2 * JC_N;
    localparam int IDXW      = $clog2(JC_STATES);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Mask with the low cnt bits set.
    function automatic logic [JC_N-1:0] jc_fill(int cnt);
        logic [JC_N-1:0] m;
        m = '0;
        for (int i = 0; i < JC_N; i++) begin
            if (i < cnt) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Ones in the filling half, zeros in the draining half.
    function automatic int jc_count(logic [JC_N-1:0] code);
        int c;
        c = 0;
        for (int i = 0; i < JC_N; i++) begin
            if (code[JC_N-1] ? !code[i] : code[i]) c++;
        end
        return c;
    endfunction

    function automatic logic [IDXW-1:0] jc_index(logic [JC_N-1:0] code);
        int c;
        c = jc_count(code);
        return code[JC_N-1] ? IDXW'(JC_N + c) : IDXW'(c);
    endfunction

    function automatic logic jc_legal(logic [JC_N-1:0] code);
        int c;
        c = jc_count(code);
        return code[JC_N-1] ? (code == ~jc_fill(c)) : (code == jc_fill(c));
    endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// johnson_decoder_if: code sample in, decoded result out.
//   slave  : decoder side (takes code_i/code_valid_i, drives *_o)
//   master : source/consumer side
interface johnson_decoder_if #(parameter int ERRW = 8);
    import johnson_pkg::*;

    logic [JC_N-1:0] code_i;
    logic            code_valid_i;
    logic [IDXW-1:0] index_o;
    logic            index_valid_o;
    logic            illegal_o;
    logic            dir_o;
    logic            step_err_o;
    logic            locked_o;
    logic [ERRW-1:0] err_cnt_o;

    modport slave (
        input  code_i, code_valid_i,
        output index_o, index_valid_o, illegal_o, dir_o, step_err_o, locked_o, err_cnt_o
    );

    modport master (
        output code_i, code_valid_i,
        input  index_o, index_valid_o, illegal_o, dir_o, step_err_o, locked_o, err_cnt_o
    );

endinterface

// File: rtl/johnson_decoder_code_check.sv
// johnson_code_check: combinational Johnson code -> state index + legality.
//   code_i   JC_N-bit code word
//   index_o  decoded index 0..2*JC_N-1 (meaningless when legal_o=0)
//   legal_o  code is one of the 2*JC_N legal patterns
module johnson_code_check
    import johnson_pkg::*;
(
    input  logic [JC_N-1:0] code_i,
    output logic [IDXW-1:0] index_o,
    output logic            legal_o
);

    assign index_o = jc_index(code_i);
    assign legal_o = jc_legal(code_i);

endmodule

// File: rtl/johnson_decoder.sv
// johnson_decoder: validates sampled Johnson codes, decodes the state index,
// tracks step direction and locks onto a clean +/-1 sequence.
//   clk, rst   clock (rising), async active-low reset
//   bus        johnson_decoder_if.slave: code_i/code_valid_i in; index_o,
//              index_valid_o, illegal_o, dir_o, step_err_o, locked_o, err_cnt_o out
// Config macro JOHNSON_DEC_ERR_CNT_EN: builds the saturating lock-loss counter;
// otherwise err_cnt_o is tied to 0.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int LOCK_CNT = 3,   // 1..15
    parameter int ERRW     = 8
) (
    input  logic               clk,
    input  logic               rst,
    johnson_decoder_if.slave   bus
);

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);

    logic [IDXW-1:0] dec_idx;
    logic            dec_legal;

    johnson_code_check u_chk (
        .code_i  (bus.code_i),
        .index_o (dec_idx),
        .legal_o (dec_legal)
    );

    lock_state_e     state_q, state_d;
    logic [IDXW-1:0] index_q, index_d;
    logic            vld_q, vld_d;
    logic            illegal_q, illegal_d;
    logic            dir_q, dir_d;
    logic            step_err_q, step_err_d;
    logic            prev_valid_q, prev_valid_d;
    logic [3:0]      good_q, good_d;
    logic            bad, good_step, loss;

    // index_q doubles as the previous index: it only moves on legal samples.
    logic [IDXW-1:0] nxt_idx, prv_idx;
    assign nxt_idx = (index_q == IDXW'(JC_STATES - 1)) ? '0 : index_q + 1'b1;
    assign prv_idx = (index_q == '0) ? IDXW'(JC_STATES - 1) : index_q - 1'b1;

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        vld_d        = 1'b0;
        illegal_d    = illegal_q;
        dir_d        = dir_q;
        step_err_d   = step_err_q;
        prev_valid_d = prev_valid_q;
        good_d       = good_q;
        bad          = 1'b0;
        good_step    = 1'b0;
        loss         = 1'b0;
        if (bus.code_valid_i) begin
            vld_d      = 1'b1;
            illegal_d  = !dec_legal;
            step_err_d = 1'b0;
            if (!dec_legal) begin
                bad = 1'b1;
            end else begin
                index_d      = dec_idx;
                prev_valid_d = 1'b1;
                if (prev_valid_q) begin
                    if (dec_idx == nxt_idx) begin
                        dir_d     = 1'b1;
                        good_step = 1'b1;
                    end else if (dec_idx == prv_idx) begin
                        dir_d     = 1'b0;
                        good_step = 1'b1;
                    end else if (dec_idx != index_q) begin
                        step_err_d = 1'b1;
                        bad        = 1'b1;
                    end
                end
            end
            case (state_q)
                SEARCH: begin
                    if (bad) begin
                        good_d = '0;
                    end else if (good_step) begin
                        if (good_q == LOCK_LAST) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    // Lock loss: next legal sample is treated as a first sample.
                    if (bad) begin
                        state_d      = SEARCH;
                        good_d       = '0;
                        prev_valid_d = 1'b0;
                        loss         = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SEARCH;
            index_q      <= '0;
            vld_q        <= 1'b0;
            illegal_q    <= 1'b0;
            dir_q        <= 1'b0;
            step_err_q   <= 1'b0;
            prev_valid_q <= 1'b0;
            good_q       <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            vld_q        <= vld_d;
            illegal_q    <= illegal_d;
            dir_q        <= dir_d;
            step_err_q   <= step_err_d;
            prev_valid_q <= prev_valid_d;
            good_q       <= good_d;
        end
    end

`ifdef JOHNSON_DEC_ERR_CNT_EN
    logic [ERRW-1:0] err_cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            err_cnt_q <= '0;
        else if (loss && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
    assign bus.err_cnt_o = err_cnt_q;
`else
    logic loss_unused;
    assign loss_unused   = loss;
    assign bus.err_cnt_o = {ERRW{1'b0}};
`endif

    assign bus.index_o       = index_q;
    assign bus.index_valid_o = vld_q;
    assign bus.illegal_o     = illegal_q;
    assign bus.dir_o         = dir_q;
    assign bus.step_err_o    = step_err_q;
    assign bus.locked_o      = (state_q == LOCKED);

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder (N=4, LOCK_CNT=3, ERRW=8).
// Observed vector obs = {index[2:0], index_valid, illegal, dir, step_err, locked}.
module tb_johnson_decoder;

`ifdef JOHNSON_DEC_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    johnson_decoder_if #(.ERRW(8)) bus ();

    johnson_decoder #(.LOCK_CNT(3), .ERRW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wire [7:0] obs = {bus.index_o, bus.index_valid_o, bus.illegal_o,
                      bus.dir_o, bus.step_err_o, bus.locked_o};

    // Present one code with code_valid for one edge; outputs settle #1 later.
    task automatic step(input logic [3:0] c);
        bus.code_i       = c;
        bus.code_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.code_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.code_i = 4'b0000;
        bus.code_valid_i = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({obs, bus.err_cnt_o} !== 16'h0) begin
            failures++;
            $display("FAIL reset got=%b err_cnt=%0d exp=0", obs, bus.err_cnt_o);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_acquire();
        logic [3:0] c[4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};
        logic [7:0] e[4] = '{8'b000_10000, 8'b001_10100, 8'b010_10100, 8'b011_10101};
        for (int i = 0; i < 4; i++) begin
            step(c[i]);
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL acquire[%0d] got=%b exp=%b", i, obs, e[i]);
            end
        end
        // Idle cycle: no pulse, everything else holds.
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 8'b011_00101) begin
            failures++;
            $display("FAIL idle_hold got=%b exp=%b", obs, 8'b011_00101);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] c[5] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        logic [7:0] e[5] = '{8'b100_10101, 8'b101_10101, 8'b110_10101,
                             8'b111_10101, 8'b000_10101};
        for (int i = 0; i < 5; i++) begin
            step(c[i]);
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL wrap[%0d] got=%b exp=%b", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_reversal();
        logic [3:0] c[4] = '{4'b0001, 4'b0011, 4'b0001, 4'b0001};
        logic [7:0] e[4] = '{8'b001_10101, 8'b010_10101, 8'b001_10001, 8'b001_10001};
        for (int i = 0; i < 4; i++) begin
            step(c[i]);
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL reversal[%0d] got=%b exp=%b", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_step_err();
        logic [3:0] c[2] = '{4'b0011, 4'b1111};
        logic [7:0] e[2] = '{8'b010_10101, 8'b100_10110};
        for (int i = 0; i < 2; i++) begin
            step(c[i]);
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL step_err[%0d] got=%b exp=%b", i, obs, e[i]);
            end
        end
        checks++;
        if (bus.err_cnt_o !== (ERR_EN ? 8'd1 : 8'd0)) begin
            failures++;
            $display("FAIL step_err_cnt got=%0d exp=%0d", bus.err_cnt_o, ERR_EN ? 1 : 0);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] c[5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b0101};
        logic [7:0] e[5] = '{8'b000_10100, 8'b001_10100, 8'b010_10100,
                             8'b011_10101, 8'b011_11100};
        for (int i = 0; i < 5; i++) begin
            step(c[i]);
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL illegal[%0d] got=%b exp=%b", i, obs, e[i]);
            end
        end
        checks++;
        if (bus.err_cnt_o !== (ERR_EN ? 8'd2 : 8'd0)) begin
            failures++;
            $display("FAIL illegal_cnt got=%0d exp=%0d", bus.err_cnt_o, ERR_EN ? 2 : 0);
        end
    endtask

    // SEARCH-state step error must not count; hold steps must not count toward lock.
    task automatic test_search_rules();
        logic [3:0] c[6] = '{4'b0000, 4'b1100, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        logic [7:0] e[6] = '{8'b000_10100, 8'b110_10110, 8'b111_10100,
                             8'b111_10100, 8'b000_10100, 8'b001_10101};
        for (int i = 0; i < 6; i++) begin
            step(c[i]);
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL search[%0d] got=%b exp=%b", i, obs, e[i]);
            end
        end
        checks++;
        if (bus.err_cnt_o !== (ERR_EN ? 8'd2 : 8'd0)) begin
            failures++;
            $display("FAIL search_cnt got=%0d exp=%0d", bus.err_cnt_o, ERR_EN ? 2 : 0);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] c[4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
        logic [7:0] e[4] = '{8'b101_10000, 8'b110_10100, 8'b111_10100, 8'b000_10101};
        step(4'b0011);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({obs, bus.err_cnt_o} !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid got=%b err_cnt=%0d exp=0", obs, bus.err_cnt_o);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(c[i]);
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL post_reset[%0d] got=%b exp=%b", i, obs, e[i]);
            end
        end
    endtask

    // 256 lock losses: counter must stop at 255 rather than wrap.
    task automatic test_err_sat();
        for (int i = 0; i < 256; i++) begin
            step(4'b0000);
            step(4'b0001);
            step(4'b0011);
            step(4'b0111);
            step(4'b0101);
            if (i == 254 || i == 255) begin
                checks++;
                if (bus.err_cnt_o !== (ERR_EN ? 8'd255 : 8'd0)) begin
                    failures++;
                    $display("FAIL err_sat[%0d] got=%0d exp=%0d", i, bus.err_cnt_o,
                             ERR_EN ? 255 : 0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_wrap();
        test_reversal();
        test_step_err();
        test_illegal();
        test_search_rules();
        test_reset_mid();
        test_err_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
